// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and channel encoding for the two-way stream demux
package demux_pkg;

    localparam int DEMUX_WIDTH = 8;
    localparam int DEMUX_CNT_W = 8;

    typedef enum logic {
        CH_B = 1'b0,
        CH_A = 1'b1
    } ch_e;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one registered output slot with valid flag, data register and beat counter
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             open
);

    // Empty, or handing its beat to the consumer this cycle.
    assign open = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            // Covers fill-while-draining: valid stays high, no bubble.
            valid <= 1'b1;
            data  <= load_data;
            count <= count + CNT_W'(1);
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_router.sv
// rtl/demux_router.sv - steers each accepted input beat into registered channel A or B
module demux_router
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [CNT_W-1:0] a_count,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] b_count
);

    ch_e  sel_ch;
    logic open_a;
    logic open_b;
    logic accept;
    logic load_a;
    logic load_b;

    assign sel_ch   = ch_e'(in_sel);
    // Readiness deliberately ignores in_valid so producers may wait on it.
    assign in_ready = (sel_ch == CH_A) ? open_a : open_b;
    assign accept   = in_valid && in_ready;
    assign load_a   = accept && (sel_ch == CH_A);
    assign load_b   = accept && (sel_ch == CH_B);

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_a),
        .load_data (in_data),
        .ready     (a_ready),
        .valid     (a_valid),
        .data      (a_data),
        .count     (a_count),
        .open      (open_a)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_b),
        .load_data (in_data),
        .ready     (b_ready),
        .valid     (b_valid),
        .data      (b_data),
        .count     (b_count),
        .open      (open_b)
    );

endmodule

// File: tb/tb_demux_router.sv
// tb/tb_demux_router.sv - directed and randomized self-checking bench for demux_router
module tb_demux_router;
    import demux_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_data;
    logic [7:0] a_count;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] b_data;
    logic [7:0] b_count;

    int checks;
    int errors;

    // Reference: each channel is a one-entry FIFO plus a modulo-256 beat tally.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         cnt_a;
    int         cnt_b;

    demux_router #(
        .WIDTH (DEMUX_WIDTH),
        .CNT_W (DEMUX_CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":a_valid"}, a_valid, qa.size() != 0);
        check({tag, ":b_valid"}, b_valid, qb.size() != 0);
        if (qa.size() != 0) check({tag, ":a_data"}, a_data, qa[0]);
        if (qb.size() != 0) check({tag, ":b_data"}, b_data, qb[0]);
        check({tag, ":a_count"}, a_count, cnt_a);
        check({tag, ":b_count"}, b_count, cnt_b);
    endtask

    // Apply one cycle of inputs, predict handshakes, clock, compare outputs.
    task automatic step(input string tag, input logic v, input logic s, input logic [7:0] d,
                        input logic ar, input logic br, output logic fired);
        logic exp_rdy;
        logic drain_a;
        logic drain_b;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
        exp_rdy = s ? (qa.size() == 0 || ar) : (qb.size() == 0 || br);
        check({tag, ":in_ready"}, in_ready, exp_rdy);
        drain_a = (qa.size() != 0) && ar;
        drain_b = (qb.size() != 0) && br;
        fired   = v && exp_rdy;
        @(posedge clk);
        #1;
        if (drain_a) void'(qa.pop_front());
        if (drain_b) void'(qb.pop_front());
        if (fired) begin
            if (s) begin
                qa.push_back(d);
                cnt_a = (cnt_a + 1) % 256;
            end else begin
                qb.push_back(d);
                cnt_b = (cnt_b + 1) % 256;
            end
        end
        check_outputs(tag);
    endtask

    initial begin
        logic       f;
        logic       rv;
        logic       rs;
        logic [7:0] rd;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        reset_model();

        // Reset then idle
        #3;
        check("rst:a_valid", a_valid, 0);
        check("rst:b_valid", b_valid, 0);
        check("rst:a_count", a_count, 0);
        check("rst:b_count", b_count, 0);
        check("rst:a_data", a_data, 0);
        check("rst:b_data", b_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        in_sel = 1'b0;
        #1;
        check("idle:in_ready_sel0", in_ready, 1);
        in_sel = 1'b1;
        #1;
        check("idle:in_ready_sel1", in_ready, 1);

        // Steering
        step("steer_a", 1'b1, CH_A, 8'd2, 1'b1, 1'b1, f);
        check("steer:a_data", a_data, 2);
        step("steer_b", 1'b1, CH_B, 8'd3, 1'b1, 1'b1, f);
        check("steer:b_data", b_data, 3);
        check("steer:a_count", a_count, 1);
        check("steer:b_count", b_count, 1);
        step("steer_idle", 1'b0, CH_A, 8'd0, 1'b1, 1'b1, f);

        // Backpressure on A; B still accepts
        step("bp_5", 1'b1, CH_A, 8'd5, 1'b0, 1'b1, f);
        step("bp_6_stall", 1'b1, CH_A, 8'd6, 1'b0, 1'b1, f);
        check("bp:stall_not_fired", f, 0);
        check("bp:a_held", a_data, 5);
        step("bp_7_to_b", 1'b1, CH_B, 8'd7, 1'b0, 1'b0, f);
        check("bp:b_accepted", f, 1);
        check("bp:b_data", b_data, 7);
        step("bp_6_drain_fill", 1'b1, CH_A, 8'd6, 1'b1, 1'b1, f);
        check("bp:6_fired", f, 1);
        check("bp:a_no_gap", a_valid, 1);
        check("bp:a_data6", a_data, 6);
        step("bp_idle", 1'b0, CH_A, 8'd0, 1'b1, 1'b1, f);

        // Counter wrap on B from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        reset_model();
        #1;
        check_outputs("wrap_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step("wrap", 1'b1, CH_B, 8'(i), 1'b0, 1'b1, f);
            if (i == 254) check("wrap:b_count255", b_count, 255);
        end
        check("wrap:b_count0", b_count, 0);
        check("wrap:a_count", a_count, 0);
        step("wrap_idle", 1'b0, CH_B, 8'd0, 1'b1, 1'b1, f);

        // Randomized traffic with held inputs while stalled
        rv = 1'b0;
        rs = 1'b0;
        rd = '0;
        f  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!rv || f) begin
                rv = 1'($urandom_range(0, 3) != 0);
                rs = 1'($urandom);
                rd = 8'($urandom);
            end
            step("rand", rv, rs, rd, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), f);
        end

        // Async reset with both slots full
        step("fill_a", 1'b1, CH_A, 8'hA5, 1'b0, 1'b0, f);
        step("fill_b", 1'b1, CH_B, 8'h5A, 1'b0, 1'b0, f);
        step("fill_a2", 1'b1, CH_A, 8'hA5, 1'b0, 1'b0, f);
        check("full:a_valid", a_valid, 1);
        check("full:b_valid", b_valid, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst:a_valid", a_valid, 0);
        check("arst:b_valid", b_valid, 0);
        check("arst:a_count", a_count, 0);
        check("arst:b_count", b_count, 0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        step("resume_a", 1'b1, CH_A, 8'h11, 1'b1, 1'b1, f);
        check("resume:fired", f, 1);
        step("resume_b", 1'b1, CH_B, 8'h22, 1'b1, 1'b1, f);
        step("resume_idle", 1'b0, CH_B, 8'h00, 1'b1, 1'b1, f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
